// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM states,
// requester IDs and the active-low memory strobe levels.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        S_Idle   = 2'd0,
        S_Access = 2'd1,
        S_Done   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    localparam logic MEM_EN_ACTIVE = 1'b0;
    localparam logic MEM_EN_IDLE   = 1'b1;
    localparam logic MEM_WR_WRITE  = 1'b0;
    localparam logic MEM_WR_READ   = 1'b1;

    // Round-robin hand-off: after a grant the other requester is favoured.
    function automatic logic other_requester(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and memory-side signals of the arbiter; the arbiter takes the
// slave modport, the environment (requesters plus memory) the master modport.
interface memory_arbiter_if #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8
);
    logic                 CPU_Req;
    logic                 CPU_Wr;
    logic [AddrWidth-1:0] CPU_Addr;
    logic [DataWidth-1:0] CPU_DIn;
    logic                 LDR_Req;
    logic                 LDR_Wr;
    logic [AddrWidth-1:0] LDR_Addr;
    logic [DataWidth-1:0] LDR_DIn;
    logic                 CPU_Ack;
    logic                 LDR_Ack;
    logic [DataWidth-1:0] RdData;
    logic                 MEM_En;
    logic                 MEM_Wr;
    logic [AddrWidth-1:0] MEM_Addr;
    logic [DataWidth-1:0] MEM_DIn;
    logic [DataWidth-1:0] MEM_DOut;
    logic                 Owner;
    logic                 Busy;

    modport slave (
        input  CPU_Req, CPU_Wr, CPU_Addr, CPU_DIn,
        input  LDR_Req, LDR_Wr, LDR_Addr, LDR_DIn,
        input  MEM_DOut,
        output CPU_Ack, LDR_Ack, RdData,
        output MEM_En, MEM_Wr, MEM_Addr, MEM_DIn,
        output Owner, Busy
    );

    modport master (
        output CPU_Req, CPU_Wr, CPU_Addr, CPU_DIn,
        output LDR_Req, LDR_Wr, LDR_Addr, LDR_DIn,
        output MEM_DOut,
        input  CPU_Ack, LDR_Ack, RdData,
        input  MEM_En, MEM_Wr, MEM_Addr, MEM_DIn,
        input  Owner, Busy
    );
endinterface

// File: rtl/memory_arbiter_priority_select.sv
// Winner selection between CPU and loader requests. Fixed CPU priority by
// default; ARB_ROUND_ROBIN_EN makes rr_ptr (the favoured requester) break ties.
module arb_priority_select
    import memory_arbiter_pkg::*;
(
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic rr_ptr,
    output logic winner,
    output logic valid
);

    // Combinational tie-break and single-request pass-through
    always_comb begin
        winner = REQ_CPU;
        valid  = cpu_req | ldr_req;
        if (cpu_req && ldr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = rr_ptr;
`else
            winner = REQ_CPU;
`endif
        end else if (ldr_req) begin
            winner = REQ_LDR;
        end else begin
            winner = REQ_CPU;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_ptr_s;
    assign unused_ptr_s = rr_ptr;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Two-requester single-port memory arbiter: Idle -> Access -> Done, one
// access per three cycles. Optional macro ARB_ROUND_ROBIN_EN enables fair ties.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8
) (
    input logic              Clk,
    input logic              Reset,
    memory_arbiter_if.slave  bus
);

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 grant_winner_s;
    logic                 grant_valid_s;
    logic                 rr_ptr_s;
    logic                 cpu_ack_r;
    logic                 ldr_ack_r;
    logic                 mem_en_r;
    logic                 mem_wr_r;
    logic                 owner_r;
    logic                 busy_r;
    logic [AddrWidth-1:0] mem_addr_r;
    logic [DataWidth-1:0] mem_din_r;
    logic [DataWidth-1:0] rd_data_r;

    arb_priority_select u_sel (
        .cpu_req (bus.CPU_Req),
        .ldr_req (bus.LDR_Req),
        .rr_ptr  (rr_ptr_s),
        .winner  (grant_winner_s),
        .valid   (grant_valid_s)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr_r;

    // Favoured requester for the next tie; handed over on every grant
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rr_ptr_r <= REQ_CPU;
        end else if (state_r == S_Idle && grant_valid_s) begin
            rr_ptr_r <= other_requester(grant_winner_s);
        end
    end
    assign rr_ptr_s = rr_ptr_r;
`else
    assign rr_ptr_s = REQ_CPU;
`endif

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= S_Idle;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = S_Idle;
        case (state_r)
            S_Idle: begin
                if (grant_valid_s) begin
                    state_nxt_s = S_Access;
                end else begin
                    state_nxt_s = S_Idle;
                end
            end
            S_Access: state_nxt_s = S_Done;
            S_Done:   state_nxt_s = S_Idle;
            default:  state_nxt_s = S_Idle;
        endcase
    end

    // Registered outputs: request latch at grant, memory strobes, read capture, Ack
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cpu_ack_r  <= 1'b0;
            ldr_ack_r  <= 1'b0;
            mem_en_r   <= MEM_EN_IDLE;
            mem_wr_r   <= MEM_WR_READ;
            mem_addr_r <= '0;
            mem_din_r  <= '0;
            rd_data_r  <= '0;
            owner_r    <= REQ_CPU;
            busy_r     <= 1'b0;
        end else begin
            cpu_ack_r <= 1'b0;
            ldr_ack_r <= 1'b0;
            mem_en_r  <= MEM_EN_IDLE;
            mem_wr_r  <= MEM_WR_READ;
            case (state_r)
                S_Idle: begin
                    if (grant_valid_s) begin
                        owner_r  <= grant_winner_s;
                        busy_r   <= 1'b1;
                        mem_en_r <= MEM_EN_ACTIVE;
                        if (grant_winner_s == REQ_LDR) begin
                            mem_wr_r   <= bus.LDR_Wr;
                            mem_addr_r <= bus.LDR_Addr;
                            mem_din_r  <= bus.LDR_DIn;
                        end else begin
                            mem_wr_r   <= bus.CPU_Wr;
                            mem_addr_r <= bus.CPU_Addr;
                            mem_din_r  <= bus.CPU_DIn;
                        end
                    end
                end
                S_Access: begin
                    // mem_wr_r still holds this access's direction here
                    if (mem_wr_r == MEM_WR_READ) begin
                        rd_data_r <= bus.MEM_DOut;
                    end
                    if (owner_r == REQ_LDR) begin
                        ldr_ack_r <= 1'b1;
                    end else begin
                        cpu_ack_r <= 1'b1;
                    end
                end
                S_Done:  busy_r <= 1'b0;
                default: busy_r <= 1'b0;
            endcase
        end
    end

    assign bus.CPU_Ack  = cpu_ack_r;
    assign bus.LDR_Ack  = ldr_ack_r;
    assign bus.RdData   = rd_data_r;
    assign bus.MEM_En   = mem_en_r;
    assign bus.MEM_Wr   = mem_wr_r;
    assign bus.MEM_Addr = mem_addr_r;
    assign bus.MEM_DIn  = mem_din_r;
    assign bus.Owner    = owner_r;
    assign bus.Busy     = busy_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, multi-cycle
// corner sequences and random transactions against a transaction-level model.
module tb_memory_arbiter;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    memory_arbiter_if bus ();

    memory_arbiter dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Memory device: asynchronous read, write on posedge while selected
    logic [15:0] mem [256];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    assign bus.MEM_DOut = mem[bus.MEM_Addr];
    always @(posedge Clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (bus.MEM_En == 1'b0 && bus.MEM_Wr == 1'b0) mem[bus.MEM_Addr] <= bus.MEM_DIn;
    end

    typedef struct {
        logic        cpu_req;
        logic        ldr_req;
        logic        cpu_wr;
        logic        ldr_wr;
        logic [7:0]  cpu_addr;
        logic [7:0]  ldr_addr;
        logic [15:0] cpu_din;
        logic [15:0] ldr_din;
        logic        scramble;
        logic        exp_owner;
        logic [15:0] exp_rd;
    } txn_t;

    // Reference model state
    logic [15:0] shadow [256];
    logic [15:0] last_rd;
    logic        fav;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_winner(input logic c, input logic l);
        if (c && l) begin
`ifdef ARB_ROUND_ROBIN_EN
            return fav;
`else
            return 1'b0;
`endif
        end
        return c ? 1'b0 : 1'b1;
    endfunction

    task automatic drop_reqs();
        bus.CPU_Req = 1'b0;
        bus.LDR_Req = 1'b0;
    endtask

    task automatic reset_pulse();
        drop_reqs();
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        fav = 1'b0;
        last_rd = 16'h0000;
    endtask

    // One full transaction: grant, access, done, back to idle
    task automatic run_txn(input txn_t t, input string tag);
        logic        win;
        logic [7:0]  a;
        logic [15:0] d;
        logic        wr;
        bus.CPU_Req = t.cpu_req;  bus.CPU_Wr = t.cpu_wr;
        bus.CPU_Addr = t.cpu_addr; bus.CPU_DIn = t.cpu_din;
        bus.LDR_Req = t.ldr_req;  bus.LDR_Wr = t.ldr_wr;
        bus.LDR_Addr = t.ldr_addr; bus.LDR_DIn = t.ldr_din;
        @(negedge Clk);
        if (!(t.cpu_req || t.ldr_req)) begin
            chk({tag, "_idle_en"}, 32'(bus.MEM_En), 32'd1);
            chk({tag, "_idle_busy"}, 32'(bus.Busy), 32'd0);
            chk({tag, "_idle_ack"}, 32'({bus.CPU_Ack, bus.LDR_Ack}), 32'd0);
            return;
        end
        win = t.exp_owner;
        a   = win ? t.ldr_addr : t.cpu_addr;
        d   = win ? t.ldr_din  : t.cpu_din;
        wr  = win ? t.ldr_wr   : t.cpu_wr;
        chk({tag, "_acc_en"}, 32'(bus.MEM_En), 32'd0);
        chk({tag, "_acc_addr"}, 32'(bus.MEM_Addr), 32'(a));
        chk({tag, "_acc_wr"}, 32'(bus.MEM_Wr), 32'(wr));
        chk({tag, "_acc_busy"}, 32'(bus.Busy), 32'd1);
        chk({tag, "_acc_owner"}, 32'(bus.Owner), 32'(win));
        if (!wr) chk({tag, "_acc_din"}, 32'(bus.MEM_DIn), 32'(d));
        if (t.scramble) begin
            bus.CPU_Req = 1'($urandom_range(0, 1)); bus.CPU_Wr = 1'($urandom_range(0, 1));
            bus.CPU_Addr = 8'($urandom); bus.CPU_DIn = 16'($urandom);
            bus.LDR_Req = 1'($urandom_range(0, 1)); bus.LDR_Wr = 1'($urandom_range(0, 1));
            bus.LDR_Addr = 8'($urandom); bus.LDR_DIn = 16'($urandom);
        end
        @(negedge Clk);
        chk({tag, "_cpu_ack"}, 32'(bus.CPU_Ack), 32'(win == 1'b0));
        chk({tag, "_ldr_ack"}, 32'(bus.LDR_Ack), 32'(win == 1'b1));
        chk({tag, "_rd"}, 32'(bus.RdData), 32'(t.exp_rd));
        chk({tag, "_done_en"}, 32'(bus.MEM_En), 32'd1);
        if (!wr) shadow[a] = d;
        else last_rd = t.exp_rd;
        fav = ~win;
        drop_reqs();
        @(negedge Clk);
        chk({tag, "_end_busy"}, 32'(bus.Busy), 32'd0);
        chk({tag, "_end_ack"}, 32'({bus.CPU_Ack, bus.LDR_Ack}), 32'd0);
    endtask

    txn_t vec [8];
    txn_t t;
    logic got_owner [8];
    int   n_grant;

    initial begin
        // Directed vectors: {creq, lreq, cwr, lwr, caddr, laddr, cdin, ldin, scramble, owner, rd}
        vec[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hA55A};
        vec[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h10, 16'h0000, 16'h1234, 1'b0, 1'b1, 16'hA55A};
        vec[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234};
`ifdef ARB_ROUND_ROBIN_EN
        vec[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'h21, 16'h0000, 16'h5555, 1'b0, 1'b1, 16'h1234};
        vec[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h30, 8'h00, 16'hCAFE, 16'h0000, 1'b1, 1'b0, 16'h1234};
        vec[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h21, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h5555};
`else
        vec[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'h21, 16'h0000, 16'h5555, 1'b0, 1'b0, 16'h20DF};
        vec[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h30, 8'h00, 16'hCAFE, 16'h0000, 1'b1, 1'b0, 16'h20DF};
        vec[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h21, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h21DE};
`endif
        vec[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vec[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h30, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hCAFE};

        Reset = 1'b0;
        pre_en = 1'b0; pre_addr = 8'h00; pre_data = 16'h0000;
        bus.CPU_Req = 1'b0; bus.CPU_Wr = 1'b1; bus.CPU_Addr = 8'h00; bus.CPU_DIn = 16'h0000;
        bus.LDR_Req = 1'b0; bus.LDR_Wr = 1'b1; bus.LDR_Addr = 8'h00; bus.LDR_DIn = 16'h0000;
        fav = 1'b0;
        last_rd = 16'h0000;
        repeat (2) @(negedge Clk);

        // Reset values
        chk("rst_en", 32'(bus.MEM_En), 32'd1);
        chk("rst_wr", 32'(bus.MEM_Wr), 32'd1);
        chk("rst_addr", 32'(bus.MEM_Addr), 32'd0);
        chk("rst_din", 32'(bus.MEM_DIn), 32'd0);
        chk("rst_rd", 32'(bus.RdData), 32'd0);
        chk("rst_ack", 32'({bus.CPU_Ack, bus.LDR_Ack}), 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_owner", 32'(bus.Owner), 32'd0);

        // Preload memory and model while the arbiter is held in reset
        for (int i = 0; i < 256; i++) begin
            pre_en = 1'b1;
            pre_addr = 8'(i);
            pre_data = (i == 4) ? 16'hA55A : {8'(i), ~8'(i)};
            shadow[i] = pre_data;
            @(negedge Clk);
        end
        pre_en = 1'b0;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("post_rst_en", 32'(bus.MEM_En), 32'd1);
        chk("post_rst_busy", 32'(bus.Busy), 32'd0);
        chk("post_rst_rd", 32'(bus.RdData), 32'h0000);

        for (int i = 0; i < 8; i++) run_txn(vec[i], $sformatf("vec%0d", i));

        // Both requests held high across four grants
        reset_pulse();
        bus.CPU_Req = 1'b1; bus.CPU_Wr = 1'b1; bus.CPU_Addr = 8'h01;
        bus.LDR_Req = 1'b1; bus.LDR_Wr = 1'b1; bus.LDR_Addr = 8'h02;
        n_grant = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            chk("both_ack_excl", 32'(bus.CPU_Ack & bus.LDR_Ack), 32'd0);
            if ((bus.CPU_Ack | bus.LDR_Ack) && n_grant < 8) begin
                got_owner[n_grant] = bus.LDR_Ack;
                n_grant++;
            end
        end
        drop_reqs();
        @(negedge Clk);
        chk("both_grant_count", 32'(n_grant), 32'd4);
        for (int g = 0; g < 4 && g < n_grant; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
            chk($sformatf("both_grant%0d", g), 32'(got_owner[g]), 32'(g % 2));
`else
            chk($sformatf("both_grant%0d", g), 32'(got_owner[g]), 32'd0);
`endif
        end

        // Requester inputs change and Req drops during the access
        reset_pulse();
        bus.CPU_Req = 1'b1; bus.CPU_Wr = 1'b1; bus.CPU_Addr = 8'h04;
        @(negedge Clk);
        chk("imm_acc_addr", 32'(bus.MEM_Addr), 32'h04);
        chk("imm_acc_en", 32'(bus.MEM_En), 32'd0);
        bus.CPU_Addr = 8'hFF;
        bus.CPU_Req = 1'b0;
        @(negedge Clk);
        chk("imm_ack", 32'(bus.CPU_Ack), 32'd1);
        chk("imm_addr_held", 32'(bus.MEM_Addr), 32'h04);
        chk("imm_rd", 32'(bus.RdData), 32'hA55A);
        @(negedge Clk);
        chk("imm_end_busy", 32'(bus.Busy), 32'd0);

        // Reset asserted in the middle of an access
        bus.CPU_Req = 1'b1; bus.CPU_Wr = 1'b1; bus.CPU_Addr = 8'h04;
        @(negedge Clk);
        chk("rmid_acc_en", 32'(bus.MEM_En), 32'd0);
        #2 Reset = 1'b0;
        #1;
        chk("rmid_en", 32'(bus.MEM_En), 32'd1);
        chk("rmid_busy", 32'(bus.Busy), 32'd0);
        chk("rmid_ack", 32'({bus.CPU_Ack, bus.LDR_Ack}), 32'd0);
        drop_reqs();
        @(negedge Clk);
        Reset = 1'b1;
        fav = 1'b0;
        last_rd = 16'h0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("rmid_after_ack", 32'({bus.CPU_Ack, bus.LDR_Ack}), 32'd0);
            chk("rmid_after_busy", 32'(bus.Busy), 32'd0);
        end
        t = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h10, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h1234};
        run_txn(t, "rmid_regrant");

        // Random transactions against the model
        for (int k = 0; k < 80; k++) begin
            t.cpu_req  = 1'($urandom_range(0, 1));
            t.ldr_req  = 1'($urandom_range(0, 1));
            t.cpu_wr   = 1'($urandom_range(0, 1));
            t.ldr_wr   = 1'($urandom_range(0, 1));
            t.cpu_addr = 8'($urandom_range(0, 31));
            t.ldr_addr = 8'($urandom_range(0, 31));
            t.cpu_din  = 16'($urandom);
            t.ldr_din  = 16'($urandom);
            t.scramble = 1'($urandom_range(0, 1));
            t.exp_owner = model_winner(t.cpu_req, t.ldr_req);
            if (t.exp_owner ? t.ldr_wr : t.cpu_wr)
                t.exp_rd = shadow[t.exp_owner ? t.ldr_addr : t.cpu_addr];
            else
                t.exp_rd = last_rd;
            run_txn(t, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
